// File: rtl/i2c_slave_ctrl.sv
// I2C slave bit/byte controller: START/STOP detection, 7-bit address match,
// write-byte capture, read-byte shift-out and open-drain SDA sequencing.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | bus free or not addressed; waits for START
// ADDR     | shifting in address byte + R/W bit
// ADDR_ACK | pulling SDA low for the address ACK clock
// WR_DATA  | shifting in a write byte from the master
// WR_ACK   | pulling SDA low for the write-byte ACK clock
// RD_DATA  | driving a read byte out, MSB first
// RD_ACK   | SDA released, sampling master ACK/NACK
// IGNORE   | transfer not for us or master NACKed; waits for START/STOP

module i2c_slave_ctrl #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_pos,
   input  logic       scl_neg,
   input  logic       sda_pos,
   input  logic       sda_neg,
   input  logic       scl_lvl,
   input  logic       sda_lvl,
   input  logic [7:0] tx_data,
   output logic       tx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       start_det,
   output logic       stop_det,
   output logic       rw,
   output logic       busy,
   output logic       sda_oe
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   state_t      state;
   logic [7:0]  shifter;
   logic [2:0]  bit_cnt;
   logic        byte_done;
   logic        mack;
   logic        start_c;
   logic        stop_c;

   assign start_c = sda_neg & scl_lvl;
   assign stop_c  = sda_pos & scl_lvl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shifter   <= 8'h00;
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         mack      <= 1'b0;
         tx_ack    <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         rw        <= 1'b0;
         busy      <= 1'b0;
         sda_oe    <= 1'b0;
      end else begin
         tx_ack    <= 1'b0;
         rx_valid  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         // Bus conditions win over any SCL strobe arriving in the same cycle.
         if (start_c) begin
            state     <= ADDR;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            sda_oe    <= 1'b0;
            start_det <= 1'b1;
            busy      <= 1'b1;
         end else if (stop_c) begin
            if (state != IDLE) begin
               state     <= IDLE;
               bit_cnt   <= 3'd0;
               byte_done <= 1'b0;
               sda_oe    <= 1'b0;
               stop_det  <= 1'b1;
               busy      <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
               end
               ADDR, WR_DATA: begin
                  if (scl_pos) begin
                     shifter <= {shifter[6:0], sda_lvl};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        byte_done <= 1'b1;
                        if (state == ADDR) begin
                           rw <= sda_lvl;
                        end else begin
                           rx_data  <= {shifter[6:0], sda_lvl};
                           rx_valid <= 1'b1;
                        end
                     end
                  end else if (scl_neg && byte_done) begin
                     byte_done <= 1'b0;
                     if (state == WR_DATA) begin
                        sda_oe <= 1'b1;
                        state  <= WR_ACK;
                     end else if (shifter[7:1] == SLAVE_ADDR) begin
                        sda_oe <= 1'b1;
                        state  <= ADDR_ACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_neg) begin
                     bit_cnt <= 3'd0;
                     if (rw) begin
                        shifter <= tx_data;
                        tx_ack  <= 1'b1;
                        sda_oe  <= ~tx_data[7];
                        state   <= RD_DATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                     end
                  end
               end
               WR_ACK: begin
                  if (scl_neg) begin
                     sda_oe <= 1'b0;
                     state  <= WR_DATA;
                  end
               end
               RD_DATA: begin
                  if (scl_pos) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) byte_done <= 1'b1;
                  end else if (scl_neg) begin
                     if (byte_done) begin
                        byte_done <= 1'b0;
                        sda_oe    <= 1'b0;
                        state     <= RD_ACK;
                     end else begin
                        // shifter[7] is the bit on the wire; present the next one
                        sda_oe  <= ~shifter[6];
                        shifter <= {shifter[6:0], 1'b0};
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_pos) begin
                     mack <= ~sda_lvl;
                  end else if (scl_neg) begin
                     if (mack) begin
                        shifter <= tx_data;
                        tx_ack  <= 1'b1;
                        sda_oe  <= ~tx_data[7];
                        bit_cnt <= 3'd0;
                        state   <= RD_DATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= IGNORE;
                     end
                  end
               end
               IGNORE: sda_oe <= 1'b0;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bus-level master tasks, a frame-level reference
// model compared every cycle, directed scenarios with literal results, then random traffic.

module tb_i2c_slave_ctrl;

   localparam logic [6:0] SLAVE = 7'h50;
   localparam int R_ADDR = 0, R_WR = 1, R_RD = 2, R_IGN = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_pos = 1'b0, scl_neg = 1'b0, sda_pos = 1'b0, sda_neg = 1'b0;
   logic       scl_lvl = 1'b1, sda_lvl = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ack, rx_valid, start_det, stop_det, rw, busy, sda_oe;
   logic [7:0] rx_data;

   i2c_slave_ctrl #(.SLAVE_ADDR(SLAVE)) dut (
      .clk(clk), .rst(rst),
      .scl_pos(scl_pos), .scl_neg(scl_neg), .sda_pos(sda_pos), .sda_neg(sda_neg),
      .scl_lvl(scl_lvl), .sda_lvl(sda_lvl), .tx_data(tx_data),
      .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
      .start_det(start_det), .stop_det(stop_det), .rw(rw), .busy(busy), .sda_oe(sda_oe)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;
   bit chk_en = 1'b0;
   int cnt_start, cnt_stop, cnt_rxv, cnt_txack, cnt_oe;

   // bus levels as the master sees them
   logic scl = 1'b1, sda = 1'b1;
   logic last_oe;

   // frame-level reference model
   bit         m_active, m_rw, m_mack;
   int         m_role, m_npos, m_acc;
   logic [7:0] m_rdbyte;
   logic [7:0] e_rx;
   bit         e_oe, e_start, e_stop, e_rxv, e_txack;

   task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_rw = 0; m_mack = 0; m_role = R_IGN; m_npos = 0; m_acc = 0;
      m_rdbyte = 8'h00; e_rx = 8'h00; e_oe = 0;
      e_start = 0; e_stop = 0; e_rxv = 0; e_txack = 0;
   endtask

   task automatic model_load();
      m_rdbyte = tx_data; e_txack = 1; e_oe = !tx_data[7];
      m_role = R_RD; m_npos = 0;
   endtask

   task automatic model_step();
      e_start = 0; e_stop = 0; e_rxv = 0; e_txack = 0;
      if (sda_neg && scl_lvl) begin
         m_active = 1; m_role = R_ADDR; m_npos = 0; m_acc = 0; e_oe = 0; e_start = 1;
      end else if (sda_pos && scl_lvl) begin
         if (m_active) begin m_active = 0; e_oe = 0; e_stop = 1; end
      end else if (m_active) begin
         if (scl_pos) begin
            if (m_role == R_ADDR || m_role == R_WR) begin
               if (m_npos < 8) begin
                  m_acc = (m_acc * 2 + int'(sda_lvl)) % 256;
                  m_npos++;
                  if (m_npos == 8) begin
                     if (m_role == R_ADDR) m_rw = sda_lvl;
                     else begin e_rx = 8'(m_acc); e_rxv = 1; end
                  end
               end else m_npos = 9;
            end else if (m_role == R_RD) begin
               if (m_npos < 9) m_npos++;
               if (m_npos == 9) m_mack = !sda_lvl;
            end
         end else if (scl_neg) begin
            case (m_role)
               R_ADDR: begin
                  if (m_npos == 8) begin
                     if ((m_acc / 2) == int'(SLAVE)) e_oe = 1;
                     else m_role = R_IGN;
                  end else if (m_npos == 9) begin
                     if (m_rw) model_load();
                     else begin e_oe = 0; m_role = R_WR; m_npos = 0; m_acc = 0; end
                  end
               end
               R_WR: begin
                  if (m_npos == 8) e_oe = 1;
                  else if (m_npos == 9) begin e_oe = 0; m_npos = 0; m_acc = 0; end
               end
               R_RD: begin
                  if (m_npos >= 1 && m_npos <= 7) e_oe = !m_rdbyte[7 - m_npos];
                  else if (m_npos == 8) e_oe = 0;
                  else if (m_npos == 9) begin
                     if (m_mack) model_load();
                     else begin e_oe = 0; m_role = R_IGN; end
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check1("sda_oe", {7'd0, sda_oe}, {7'd0, e_oe});
         check1("busy", {7'd0, busy}, {7'd0, m_active});
         check1("rw", {7'd0, rw}, {7'd0, m_rw});
         check1("rx_data", rx_data, e_rx);
         check1("rx_valid", {7'd0, rx_valid}, {7'd0, e_rxv});
         check1("tx_ack", {7'd0, tx_ack}, {7'd0, e_txack});
         check1("start_det", {7'd0, start_det}, {7'd0, e_start});
         check1("stop_det", {7'd0, stop_det}, {7'd0, e_stop});
         cnt_start += int'(start_det);
         cnt_stop  += int'(stop_det);
         cnt_rxv   += int'(rx_valid);
         cnt_txack += int'(tx_ack);
         cnt_oe    += int'(sda_oe);
      end
   end

   task automatic clear_counts();
      cnt_start = 0; cnt_stop = 0; cnt_rxv = 0; cnt_txack = 0; cnt_oe = 0;
   endtask

   task automatic step(input logic sp, input logic sn, input logic dp, input logic dn);
      @(negedge clk); #1;
      rst = 1'b0;
      scl_pos = sp; scl_neg = sn; sda_pos = dp; sda_neg = dn;
      scl_lvl = scl; sda_lvl = sda;
      model_step();
   endtask

   task automatic reset_pulse();
      @(negedge clk); #1;
      rst = 1'b1;
      scl_pos = 0; scl_neg = 0; sda_pos = 0; sda_neg = 0;
      scl_lvl = scl; sda_lvl = sda;
      model_reset();
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rnd_idle();
      idles(int'($urandom_range(0, 2)));
   endtask

   task automatic scl_rise();
      scl = 1'b1; step(1'b1, 1'b0, 1'b0, 1'b0); rnd_idle();
   endtask

   task automatic scl_fall();
      scl = 1'b0; step(1'b0, 1'b1, 1'b0, 1'b0); rnd_idle();
   endtask

   task automatic set_sda(input logic b);
      if (sda != b) begin
         sda = b; step(1'b0, 1'b0, b, ~b); rnd_idle();
      end
   endtask

   // one SCL clock with the given SDA value; records slave drive just before the rise
   task automatic send_bit(input logic b);
      if (scl) scl_fall();
      set_sda(b);
      idles(1);
      last_oe = sda_oe;
      scl_rise();
   endtask

   task automatic i2c_start();
      if (scl) scl_fall();
      set_sda(1'b1);
      if ($urandom_range(0, 3) == 0) begin
         scl = 1'b1; sda = 1'b0; step(1'b1, 1'b0, 1'b0, 1'b1);
      end else begin
         scl_rise();
         sda = 1'b0; step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      rnd_idle();
   endtask

   task automatic i2c_stop();
      if (scl) scl_fall();
      set_sda(1'b0);
      scl_rise();
      sda = 1'b1; step(1'b0, 1'b0, 1'b1, 1'b0);
      rnd_idle();
   endtask

   task automatic wbyte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      send_bit(1'b0);
      ack = last_oe;
   endtask

   task automatic rbyte(input logic [7:0] b, input logic mack, output logic [7:0] got);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         got[i] = last_oe;
      end
      send_bit(~mack);
   endtask

   initial begin
      logic       a1, a2;
      logic [7:0] g1, g2;

      model_reset();
      clear_counts();
      reset_pulse();
      idles(1);
      chk_en = 1'b1;
      idles(1);
      check1("reset_busy", {7'd0, busy}, 8'h00);
      check1("reset_oe", {7'd0, sda_oe}, 8'h00);
      check1("reset_rx", rx_data, 8'h00);

      // write 0xA5 to our address
      clear_counts();
      i2c_start(); wbyte(8'hA0, a1); wbyte(8'hA5, a2); i2c_stop(); idles(3);
      check1("wr_addr_ack", {7'd0, a1}, 8'h01);
      check1("wr_data_ack", {7'd0, a2}, 8'h01);
      check1("wr_rx_data", rx_data, 8'hA5);
      check1("wr_rxv_cnt", 8'(cnt_rxv), 8'd1);
      check1("wr_start_cnt", 8'(cnt_start), 8'd1);
      check1("wr_stop_cnt", 8'(cnt_stop), 8'd1);
      check1("wr_busy_end", {7'd0, busy}, 8'h00);

      // foreign address 0x51
      clear_counts();
      i2c_start(); wbyte(8'hA2, a1); wbyte(8'hFF, a2); i2c_stop(); idles(3);
      check1("nm_oe_cycles", 8'(cnt_oe), 8'd0);
      check1("nm_rxv_cnt", 8'(cnt_rxv), 8'd0);
      check1("nm_busy_end", {7'd0, busy}, 8'h00);

      // read two bytes, ACK then NACK
      clear_counts();
      i2c_start(); wbyte(8'hA1, a1);
      tx_data = 8'h3C; rbyte(8'h3C, 1'b1, g1);
      tx_data = 8'hC3; rbyte(8'hC3, 1'b0, g2);
      i2c_stop(); idles(3);
      check1("rd_addr_ack", {7'd0, a1}, 8'h01);
      check1("rd_byte0_oe", g1, 8'hC3);
      check1("rd_byte1_oe", g2, 8'h3C);
      check1("rd_txack_cnt", 8'(cnt_txack), 8'd2);
      check1("rd_oe_end", {7'd0, sda_oe}, 8'h00);

      // write then repeated START into a read
      clear_counts();
      i2c_start(); wbyte(8'hA0, a1); wbyte(8'h12, a2);
      i2c_start(); wbyte(8'hA1, a1);
      tx_data = 8'h55; rbyte(8'h55, 1'b0, g1);
      i2c_stop(); idles(3);
      check1("rs_rx_data", rx_data, 8'h12);
      check1("rs_start_cnt", 8'(cnt_start), 8'd2);
      check1("rs_rw", {7'd0, rw}, 8'h01);
      check1("rs_rd_oe", g1, 8'hAA);

      // STOP after four data bits
      clear_counts();
      i2c_start(); wbyte(8'hA0, a1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_stop(); idles(3);
      check1("ps_rxv_cnt", 8'(cnt_rxv), 8'd0);
      check1("ps_rx_data", rx_data, 8'h12);
      check1("ps_busy", {7'd0, busy}, 8'h00);

      // reset while ACKing the address
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA0 >> i) & 8'h01));
      scl_fall(); idles(1);
      check1("rs_ack_oe", {7'd0, sda_oe}, 8'h01);
      reset_pulse(); idles(1);
      check1("rs_after_oe", {7'd0, sda_oe}, 8'h00);
      check1("rs_after_busy", {7'd0, busy}, 8'h00);
      clear_counts();
      scl_rise(); wbyte(8'h5A, a1); wbyte(8'hA0, a2); idles(2);
      check1("rs_dead_oe", 8'(cnt_oe), 8'd0);
      i2c_start(); wbyte(8'hA0, a1); i2c_stop(); idles(2);
      check1("rs_recover_ack", {7'd0, a1}, 8'h01);

      // random traffic
      for (int t = 0; t < 40; t++) begin
         logic [6:0] a;
         logic       r, ak;
         logic [7:0] d, g;
         int         nb, nbits;
         a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE;
         r  = 1'($urandom);
         nb = int'($urandom_range(1, 3));
         i2c_start();
         wbyte({a, r}, ak);
         for (int k = 0; k < nb; k++) begin
            d = 8'($urandom);
            if (r) begin
               tx_data = d;
               rbyte(d, (k < nb - 1) ? 1'($urandom) : 1'b0, g);
            end else begin
               wbyte(d, ak);
            end
         end
         case ($urandom_range(0, 5))
            0: begin
               nbits = int'($urandom_range(1, 7));
               for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
               i2c_stop();
            end
            1: begin
               send_bit(1'($urandom));
               reset_pulse();
            end
            2: ;
            default: i2c_stop();
         endcase
      end
      i2c_stop();
      idles(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
